// File: rtl/led_pkg.sv
// Shared mode codes and FSM state encodings for the LED sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ALT     = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step timebase: counts 0..period-1 while enabled and flags the last count.
module led_tick_gen #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    // period is guaranteed non-zero by the caller, so period-1 never wraps
    assign tick = en && (cnt == period - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: command handshake, step timebase and OFF/ALT/CHASE/BREATHE patterns.
// Optional LED_PWM_GATE_EN: ANDs every led bit with the synchronised pwm_in pin.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned     N_LED      = 2,
    parameter int unsigned     CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD = 32'd25000000,
    parameter int unsigned     PWM_W      = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             pwm_in,
    output logic [N_LED-1:0] led,
    output logic             timer_out,
    output logic             busy
);

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    state_e           state;
    state_e           next_state;
    mode_e            mode_r;
    logic [CNT_W-1:0] period_r;
    logic             accept;
    logic             tick;
    logic             phase;
    logic [N_LED-1:0] chase;
    logic [PWM_W-1:0] duty;
    logic             dir_down;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_s1;
    logic             pwm_s2;
    logic [N_LED-1:0] pattern;
    logic [N_LED-1:0] led_r;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = (state != ST_LOAD);
        accept     = cmd_valid && cmd_ready;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (accept) next_state = ST_LOAD;
            ST_LOAD: next_state = (mode_r == MODE_OFF) ? ST_IDLE : ST_RUN;
            ST_RUN:  if (accept) next_state = ST_LOAD;
            default: next_state = ST_IDLE;
        endcase
    end

    // The command is captured on the accepting edge so the master may drop it at once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r   <= MODE_OFF;
            period_r <= DEF_PERIOD;
        end else if (accept) begin
            mode_r   <= mode_e'(cmd_mode);
            period_r <= (cmd_period == '0) ? CNT_W'(1) : cmd_period;
        end
    end

    led_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clr    (state == ST_LOAD),
        .en     (state == ST_RUN),
        .period (period_r),
        .tick   (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase    <= 1'b0;
            chase    <= '0;
            duty     <= '0;
            dir_down <= 1'b0;
        end else if (state == ST_LOAD) begin
            phase    <= 1'b0;
            chase    <= N_LED'(1);
            duty     <= '0;
            dir_down <= 1'b0;
        end else if (state == ST_RUN && tick) begin
            case (mode_r)
                MODE_ALT:   phase <= ~phase;
                MODE_CHASE: chase <= {chase[N_LED-2:0], chase[N_LED-1]};
                MODE_BREATHE: begin
                    // Triangle ramp; direction flips on the step that lands on an end stop
                    if (!dir_down) begin
                        if (duty != DUTY_MAX) duty <= duty + PWM_W'(1);
                        if (duty >= DUTY_MAX - PWM_W'(1)) dir_down <= 1'b1;
                    end else begin
                        if (duty != '0) duty <= duty - PWM_W'(1);
                        if (duty <= PWM_W'(1)) dir_down <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt <= '0;
            pwm_s1  <= 1'b0;
            pwm_s2  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            pwm_s1  <= pwm_in;
            pwm_s2  <= pwm_s1;
        end
    end

    always_comb begin
        pattern = '0;
        if (state == ST_RUN) begin
            case (mode_r)
                MODE_ALT: begin
                    for (int i = 0; i < N_LED; i++) pattern[i] = i[0] ? phase : ~phase;
                end
                MODE_CHASE:   pattern = chase;
                MODE_BREATHE: pattern = {N_LED{pwm_cnt < duty}};
                default:      pattern = '0;
            endcase
        end
    end

    // The LOAD cycle holds the previous drive so a restart never blanks the bank
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_r <= '0;
        end else if (state != ST_LOAD) begin
            led_r <= pattern;
        end
    end

`ifdef LED_PWM_GATE_EN
    assign led = led_r & {N_LED{pwm_s2}};
`else
    assign led = led_r;
`endif

    assign timer_out = led_r[0] & pwm_s2;

endmodule
